// File: rtl/mtx_byte_unpacker.sv
// Turns the host byte stream into matrix cells for mtx_decoder: SYNC byte, then
// eight 3-byte cell groups; aborts on a bad header or an inter-byte gap timeout.
module mtx_byte_unpacker #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [18:0] matrix_cell,
  output logic        imag,
  output logic        row,
  output logic        col,
  output logic        ready,
  output logic        new_mtx,
  output logic        busy,
  output logic        err
);

  localparam int             GW       = $clog2(TIMEOUT);
  localparam logic [GW-1:0]  GAP_LAST = GW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HDR, B1, B2} state_t;

  state_t         state;
  logic [2:0]     count;
  logic [GW-1:0]  gap;
  logic [2:0]     stg_idx;
  logic [2:0]     stg_hi;
  logic [7:0]     stg_mid;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      gap         <= '0;
      stg_idx     <= '0;
      stg_hi      <= '0;
      stg_mid     <= '0;
      matrix_cell <= '0;
      imag        <= 1'b0;
      row         <= 1'b0;
      col         <= 1'b0;
      ready       <= 1'b0;
      new_mtx     <= 1'b0;
      err         <= 1'b0;
    end else begin
      ready   <= 1'b0;
      new_mtx <= 1'b0;
      err     <= 1'b0;
      if (state == IDLE) begin
        gap <= '0;
        if (rx_valid && rx_data == SYNC) begin
          new_mtx <= 1'b1;
          count   <= '0;
          state   <= HDR;
        end
      end else if (rx_valid) begin
        // A byte landing on the last gap cycle is still accepted.
        gap <= '0;
        case (state)
          HDR: begin
            if (rx_data[4:3] != 2'b00) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              stg_idx <= rx_data[7:5];
              stg_hi  <= rx_data[2:0];
              state   <= B1;
            end
          end
          B1: begin
            stg_mid <= rx_data;
            state   <= B2;
          end
          B2: begin
            // Whole cell is published at once from the staging registers.
            matrix_cell        <= {stg_hi, stg_mid, rx_data};
            {imag, row, col}   <= stg_idx;
            ready              <= 1'b1;
            count              <= count + 3'd1;
            state              <= (count == 3'd7) ? IDLE : HDR;
          end
          default: state <= IDLE;
        endcase
      end else if (gap == GAP_LAST) begin
        err   <= 1'b1;
        gap   <= '0;
        state <= IDLE;
      end else begin
        gap <= gap + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mtx_byte_unpacker.sv
// Scoreboard bench for mtx_byte_unpacker with a short timeout; expected events
// carry the cycle they must appear in, a negedge monitor pops and compares.
module tb_mtx_byte_unpacker;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int K_NEW = 0, K_CELL = 1, K_ERR = 2;

  logic        clk, reset, rx_valid, imag, row, col, ready, new_mtx, busy, err;
  logic [7:0]  rx_data;
  logic [18:0] matrix_cell;

  mtx_byte_unpacker #(.SYNC(SYNC), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .matrix_cell(matrix_cell), .imag(imag), .row(row), .col(col),
    .ready(ready), .new_mtx(new_mtx), .busy(busy), .err(err)
  );

  typedef struct {
    int          kind;
    int          cyc;
    logic [2:0]  idx;
    logic [18:0] val;
    int          busy_exp;
  } exp_t;

  exp_t        q[$];
  int          n_cmp, n_bad, cyc;
  bit          mon_en;
  logic [18:0] vals[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at, input logic [2:0] idx,
                      input logic [18:0] val, input int b);
    exp_t e;
    e.kind = kind; e.cyc = at; e.idx = idx; e.val = val; e.busy_exp = b;
    q.push_back(e);
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  task automatic observe(input int kind, input logic [2:0] idx, input logic [18:0] val);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_event: kind %0d idx %0d val %h at cycle %0d, none expected",
               kind, idx, val, cyc);
      return;
    end
    e = q.pop_front();
    check("event_kind", kind, e.kind);
    check("event_cycle", cyc, e.cyc);
    if (kind == K_CELL) begin
      check("cell_idx", int'(idx), int'(e.idx));
      check("cell_val", int'(val), int'(e.val));
    end
    if (e.busy_exp >= 0) check("busy_at_event", int'(busy), e.busy_exp);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (new_mtx) observe(K_NEW, 3'd0, 19'd0);
      if (ready)   observe(K_CELL, {imag, row, col}, matrix_cell);
      if (err)     observe(K_ERR, 3'd0, 19'd0);
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] hdr_of(input logic [2:0] idx, input logic [18:0] v);
    return {idx, 2'b00, v[18:16]};
  endfunction

  task automatic send_cell(input logic [2:0] idx, input logic [18:0] v);
    send(hdr_of(idx, v));
    send(v[15:8]);
    push(K_CELL, cyc + 1, idx, v, -1);
    send(v[7:0]);
  endtask

  task automatic send_sync();
    push(K_NEW, cyc + 1, 3'd0, 19'd0, 1);
    send(SYNC);
  endtask

  task automatic send_frame(input bit rev);
    send_sync();
    for (int i = 0; i < 8; i++)
      send_cell(rev ? 3'(7 - i) : 3'(i), vals[i]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cell"}, int'(matrix_cell), 0);
    check({tag, "_irc"}, int'({imag, row, col}), 0);
    check({tag, "_pulses"}, int'({ready, new_mtx, err}), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    vals[0] = 19'h00001; vals[1] = 19'h7FFFF; vals[2] = 19'h40000; vals[3] = 19'h0A5A5;
    vals[4] = 19'h12345; vals[5] = 19'h3FFFF; vals[6] = 19'h00000; vals[7] = 19'h5A5A5;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; mon_en = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Nominal frame, immediately followed by a second frame in reverse index order.
    send_frame(1'b0);
    send_frame(1'b1);
    check("busy_after_frame", int'(busy), 0);
    check("last_cell_held", int'(matrix_cell), int'(vals[7]));
    idle(3);

    // Leading garbage is ignored.
    send(8'h00);
    send(8'hFF);
    idle(1);
    send_frame(1'b0);
    idle(2);

    // Bad header aborts, then a clean frame decodes.
    send_sync();
    push(K_ERR, cyc + 1, 3'd0, 19'd0, 0);
    send(8'h08);
    idle(2);
    send_frame(1'b0);
    idle(2);

    // Timeout: sixteen silent cycles after a data byte.
    send_sync();
    send(hdr_of(3'd2, 19'h12345));
    send(8'h23);
    push(K_ERR, cyc + 16, 3'd0, 19'd0, 0);
    idle(18);
    check("busy_after_timeout", int'(busy), 0);

    // Bytes arriving on gap 14 and on the last gap cycle are both accepted.
    send_sync();
    send(hdr_of(3'd0, vals[0]));
    send(vals[0][15:8]);
    idle(14);
    push(K_CELL, cyc + 1, 3'd0, vals[0], 1);
    send(vals[0][7:0]);
    idle(15);
    send_cell(3'd1, vals[1]);
    for (int i = 2; i < 8; i++) send_cell(3'(i), vals[i]);
    check("busy_after_gapped_frame", int'(busy), 0);
    idle(2);

    // Reset coincident with the final byte of the fifth cell.
    send_sync();
    for (int i = 0; i < 4; i++) send_cell(3'(i), vals[i]);
    send(hdr_of(3'd4, vals[4]));
    send(vals[4][15:8]);
    rx_data = vals[4][7:0];
    rx_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b0;
    check_all_zero("midreset");
    idle(20);
    check("no_pulse_after_reset", int'({ready, err, busy}), 0);
    send_frame(1'b1);
    idle(5);

    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mtx_byte_unpacker.md
# mtx_byte_unpacker

Converts the host byte stream (one 8-bit byte per `rx_valid` strobe from the UART receiver) into the serial matrix-cell transmission consumed by `mtx_decoder`. It recognises a frame sync byte, then assembles eight 19-bit complex-matrix cells from 3-byte groups. It drives `matrix_cell`/`imag`/`row`/`col`/`ready`/`new_mtx` for the decoder, and flags malformed or stalled frames.

## Interface
- `SYNC`, default 8'hA5: frame start byte, recognised only in IDLE.
- `TIMEOUT`, default 100000: max clk cycles between bytes inside a frame before abort; must be ≥ 2.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `rx_data`  in  8  received byte, valid only when `rx_valid`.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `matrix_cell`  out  19  assembled cell value (two's-complement fixed point, passed through untouched).
- `imag`  out  1  cell is imaginary part.
- `row`  out  1  cell row index.
- `col`  out  1  cell column index.
- `ready`  out  1  one-cycle pulse: cell outputs valid this cycle.
- `new_mtx`  out  1  one-cycle pulse: new frame started.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `err`  out  1  one-cycle pulse: frame aborted (bad header or timeout).

## Operation
- Frame: `SYNC`, then 8 cell groups of 3 bytes each, 25 bytes total.
- Header byte layout: [7]=imag, [6]=row, [5]=col, [4:3] must be 2'b00, [2:0]=cell[18:16].
- Byte 2 = cell[15:8]; byte 3 = cell[7:0].
- Cells may arrive in any order; duplicates are accepted and passed on unchanged (completeness is judged downstream).
- States: IDLE, HDR, B1, B2. All transitions occur only on `rx_valid` unless noted.
  - IDLE: byte == `SYNC` → pulse `new_mtx`, cell count := 0, go HDR. Any other byte is ignored.
  - HDR: if [4:3] ≠ 0 → pulse `err`, go IDLE. Otherwise latch index and cell[18:16], go B1.
  - B1: latch cell[15:8], go B2.
  - B2: latch cell[7:0], pulse `ready`, increment count. If count was 7 → IDLE, else HDR.
- `SYNC` value seen in HDR/B1/B2 is treated as data. There is no mid-frame resync; recovery is via timeout or error.
- Gap counter:
  - Cleared on entering HDR and on every accepted byte.
  - Increments each cycle in HDR/B1/B2 without `rx_valid`.
  - When it equals `TIMEOUT-1` with `rx_valid` low → pulse `err`, go IDLE. No `ready` is produced for the partial cell.
- `matrix_cell`, `imag`, `row`, `col` change only when `ready` pulses and hold between pulses. Cell bytes are staged internally, so the downstream never sees a partially updated cell.

## Timing
- Reset values: state IDLE, count 0, gap counter 0, `matrix_cell` 0, `imag`/`row`/`col` 0, `ready`/`new_mtx`/`busy`/`err` 0.
- `new_mtx` is high the cycle after the `SYNC` byte's `rx_valid` cycle. `busy` rises in that same cycle.
- `ready` is high the cycle after the third byte's `rx_valid` cycle, with cell outputs already valid in that cycle.
- After the 8th `ready`, `busy` is low in the following cycle.
- Back-to-back `rx_valid` (every cycle) must be supported with no byte lost. A `SYNC` arriving the cycle after the final B2 byte starts a new frame.
- `err` is high for exactly one cycle, the cycle after the offending header byte or the timeout cycle. `busy` drops in that same cycle.
- Reset dominates every other event, including mid-frame: no `ready`/`err` pulse results.
- `rx_valid` in the same cycle the gap counter hits `TIMEOUT-1`: the byte is accepted and no timeout fires.
- Minimum `ready` spacing is 3 cycles.

## Test plan
- Nominal frame: `SYNC`, then cell groups {imag,row,col}=0..7 carrying values 19'h00001, 19'h7FFFF, 19'h40000, … sent back-to-back → one `new_mtx`, 8 `ready` pulses 3 cycles apart, each carrying the exact index/value; `busy` low after the 8th.
- Leading garbage: bytes 8'h00, 8'hFF, then a nominal frame → garbage ignored; output identical to the nominal frame.
- Bad header: `SYNC`, then header 8'h08 → `err` pulse one cycle later, no `ready`. A following full frame decodes correctly.
- Timeout (`TIMEOUT`=16): `SYNC`, header, one data byte, then silence → `err` exactly 16 cycles after the last byte. A byte arriving at cycle 15 instead → no `err`.
- Reset mid-frame after 4 cells → all outputs 0 next cycle, no pulses. A new frame then produces 8 cells.
- Data byte equal to `SYNC` (cell value 19'h0A5A5) → decoded as data, `new_mtx` not re-pulsed.
